// File: rtl/cim_pkg.sv
`default_nettype none
// ============================================================================
//  Module  : cim_pkg
//  Brief   : Shared types and helpers for the CIM layer bridges.
//  Rev     : 1.0  initial release
// ============================================================================
package cim_pkg;

    typedef enum logic [1:0] {
        FILL      = 2'd0,
        START     = 2'd1,
        WAIT_BUSY = 2'd2,
        WAIT_DONE = 2'd3
    } flatten_state_t;

    // Address width for an n-entry buffer; never narrower than one bit.
    function automatic int addr_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/vec_fifo.sv
`default_nettype none
// ============================================================================
//  Module  : vec_fifo
//  Brief   : Synchronous FIFO of channel vectors, same-cycle push and pop.
//  Rev     : 1.0  initial release
// ============================================================================
module vec_fifo #(
    parameter int WIDTH = 10,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic             w_push;
    logic             w_pop;

    assign full   = (r_count == CNT_W'(DEPTH));
    assign empty  = (r_count == '0);
    assign w_push = push & ~full;
    assign w_pop  = pop & ~empty;
    assign head   = r_mem[r_rd_ptr];

    // Depth is a power of two, so the pointers wrap naturally.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= push_data;
        end
    end

endmodule
`default_nettype wire

// File: rtl/pool_fc_flatten.sv
`default_nettype none
// ============================================================================
//  Module  : pool_fc_flatten
//  Brief   : Flattens pooled channel vectors (HWC) into the fc input buffer
//            and hands the completed frame to the fc layer.
//  Rev     : 1.0  initial release
// ============================================================================
module pool_fc_flatten
    import cim_pkg::*;
#(
    parameter  int INPUT_CHANNELS = 5,
    parameter  int POOLED_WIDTH   = 12,
    parameter  int DATATYPE_SIZE  = 2,
    parameter  int FIFO_DEPTH     = 2,
    localparam int OUTPUT_SIZE    = INPUT_CHANNELS * POOLED_WIDTH * POOLED_WIDTH
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             i_valid,
    input  logic [DATATYPE_SIZE-1:0]         i_data [INPUT_CHANNELS-1:0],
    output logic                             o_busy,
    output logic                             o_ibuf_we,
    output logic [DATATYPE_SIZE-1:0]         o_ibuf_wr_data,
    output logic [addr_w(OUTPUT_SIZE)-1:0]   o_ibuf_addr,
    output logic                             o_start,
    input  logic                             i_fc_busy
);

    localparam int AW     = addr_w(OUTPUT_SIZE);
    localparam int PX_W   = $clog2(POOLED_WIDTH * POOLED_WIDTH + 1);
    localparam int CH_W   = (INPUT_CHANNELS > 1) ? $clog2(INPUT_CHANNELS) : 1;
    localparam int WORD_W = INPUT_CHANNELS * DATATYPE_SIZE;

    localparam logic [PX_W-1:0] c_num_px  = PX_W'(POOLED_WIDTH * POOLED_WIDTH);
    localparam logic [PX_W-1:0] c_last_px = PX_W'(POOLED_WIDTH * POOLED_WIDTH - 1);
    localparam logic [CH_W-1:0] c_last_ch = CH_W'(INPUT_CHANNELS - 1);

    flatten_state_t    r_state;
    logic [PX_W-1:0]   r_px;
    logic [CH_W-1:0]   r_ch;
    logic [PX_W-1:0]   r_accepted;

    logic [WORD_W-1:0] w_push_word;
    logic [WORD_W-1:0] w_head;
    logic              w_fifo_full;
    logic              w_fifo_empty;
    logic              w_accept;
    logic              w_we;
    logic              w_last_ch;
    logic              w_pop;
    logic              w_last_addr;
    logic              w_release;
    logic [AW-1:0]     w_addr;

    for (genvar g = 0; g < INPUT_CHANNELS; g++) begin : g_pack
        assign w_push_word[g*DATATYPE_SIZE +: DATATYPE_SIZE] = i_data[g];
    end

    vec_fifo #(
        .WIDTH (WORD_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (w_accept),
        .push_data (w_push_word),
        .pop       (w_pop),
        .head      (w_head),
        .full      (w_fifo_full),
        .empty     (w_fifo_empty)
    );

    // The fc handing the buffer back releases the pool in the same cycle.
    assign w_release   = (r_state == WAIT_DONE) & ~i_fc_busy;
    assign o_busy      = (r_state == FILL) ? (w_fifo_full | (r_accepted == c_num_px))
                                           : ~w_release;
    assign w_accept    = i_valid & ~o_busy;
    assign w_we        = (r_state == FILL) & ~w_fifo_empty;
    assign w_last_ch   = (r_ch == c_last_ch);
    assign w_pop       = w_we & w_last_ch;
    assign w_last_addr = w_last_ch & (r_px == c_last_px);
    assign w_addr      = AW'(r_px) * AW'(INPUT_CHANNELS) + AW'(r_ch);

    assign o_ibuf_we      = w_we;
    assign o_ibuf_addr    = w_we ? w_addr : '0;
    assign o_ibuf_wr_data = w_we ? w_head[r_ch*DATATYPE_SIZE +: DATATYPE_SIZE] : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= FILL;
            o_start    <= 1'b0;
            r_px       <= '0;
            r_ch       <= '0;
            r_accepted <= '0;
        end else begin
            o_start <= 1'b0;
            case (r_state)
                FILL: begin
                    if (w_we) begin
                        if (w_last_ch) begin
                            r_ch <= '0;
                            if (r_px != c_num_px) begin
                                r_px <= r_px + 1'b1;
                            end
                        end else begin
                            r_ch <= r_ch + 1'b1;
                        end
                        if (w_last_addr) begin
                            r_state <= START;
                            o_start <= 1'b1;
                        end
                    end
                end
                START: begin
                    r_state <= WAIT_BUSY;
                end
                WAIT_BUSY: begin
                    if (i_fc_busy) begin
                        r_state <= WAIT_DONE;
                    end
                end
                WAIT_DONE: begin
                    if (!i_fc_busy) begin
                        r_state <= FILL;
                        r_px    <= '0;
                        r_ch    <= '0;
                    end
                end
                default: begin
                    r_state <= FILL;
                end
            endcase

            // A vector taken on the release cycle is the first of the next frame.
            if (w_release) begin
                r_accepted <= w_accept ? PX_W'(1) : '0;
            end else if (w_accept && (r_accepted != c_num_px)) begin
                r_accepted <= r_accepted + 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_pool_fc_flatten.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module  : tb_pool_fc_flatten
//  Brief   : Directed scoreboard bench for pool_fc_flatten.
//  Rev     : 1.0  initial release
// ============================================================================
module tb_pool_fc_flatten;

    localparam int C   = 5;
    localparam int DW  = 2;
    localparam int NPX = 144;
    localparam int OSZ = 720;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          i_valid = 1'b0;
    logic          i_fc_busy = 1'b0;
    logic [DW-1:0] i_data [C-1:0];
    logic          o_busy, o_ibuf_we, o_start;
    logic [DW-1:0] o_ibuf_wr_data;
    logic [9:0]    o_ibuf_addr;

    logic          s_valid = 1'b0;
    logic          s_fc_busy = 1'b0;
    logic [DW-1:0] s_data [0:0];
    logic          s_busy, s_we, s_start;
    logic [DW-1:0] s_wr_data;
    logic [1:0]    s_addr;

    always #5 clk = ~clk;

    pool_fc_flatten dut (
        .clk(clk), .rst(rst), .i_valid(i_valid), .i_data(i_data), .o_busy(o_busy),
        .o_ibuf_we(o_ibuf_we), .o_ibuf_wr_data(o_ibuf_wr_data), .o_ibuf_addr(o_ibuf_addr),
        .o_start(o_start), .i_fc_busy(i_fc_busy)
    );

    pool_fc_flatten #(.INPUT_CHANNELS(1), .POOLED_WIDTH(2)) dut_small (
        .clk(clk), .rst(rst), .i_valid(s_valid), .i_data(s_data), .o_busy(s_busy),
        .o_ibuf_we(s_we), .o_ibuf_wr_data(s_wr_data), .o_ibuf_addr(s_addr),
        .o_start(s_start), .i_fc_busy(s_fc_busy)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    typedef struct packed {
        logic [9:0]    addr;
        logic [DW-1:0] data;
    } exp_t;

    exp_t sb[$];
    int   exp_addr  = 0;
    logic exp_start = 1'b0;
    int   n_writes  = 0;
    int   n_starts  = 0;
    int   cyc       = 0;
    int   first_wr  = -1;
    int   last_wr   = -1;
    logic busy_seen = 1'b0;

    // Scoreboard: expected writes are queued when a vector is accepted.
    always @(negedge clk) begin
        exp_t e;
        cyc++;
        if (rst) begin
            sb.delete();
            exp_addr  = 0;
            exp_start = 1'b0;
        end else begin
            chk("start_pulse", o_start, exp_start);
            exp_start = 1'b0;
            if (o_start) n_starts++;
            if (o_ibuf_we) begin
                n_writes++;
                if (first_wr < 0) first_wr = cyc;
                last_wr = cyc;
                if (sb.size() == 0) begin
                    chk("spurious_we", o_ibuf_we, 0);
                end else begin
                    e = sb.pop_front();
                    chk("addr", o_ibuf_addr, e.addr);
                    chk("data", o_ibuf_wr_data, e.data);
                    if (e.addr == 10'(OSZ - 1)) exp_start = 1'b1;
                end
            end
            if (i_valid && !o_busy) begin
                for (int ch = 0; ch < C; ch++) begin
                    sb.push_back(exp_t'{addr: exp_addr[9:0], data: i_data[ch]});
                    exp_addr = (exp_addr == OSZ - 1) ? 0 : exp_addr + 1;
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_px(input int px);
        for (int ch = 0; ch < C; ch++) i_data[ch] = DW'((px + ch) % 4);
        i_valid = 1'b1;
    endtask

    task automatic send_px(input int px);
        int n = 0;
        drive_px(px);
        @(negedge clk);
        while (o_busy && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) chk("accept_timeout", o_busy, 0);
        if (n > 0) busy_seen = 1'b1;
        tick();
    endtask

    task automatic wait_start();
        int n = 0;
        @(negedge clk);
        while (!o_start && n < 3000) begin
            @(negedge clk);
            n++;
        end
        chk("start_seen", o_start, 1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int w0;
        int s0;
        for (int ch = 0; ch < C; ch++) i_data[ch] = '0;
        s_data[0] = '0;

        // Reset state
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_busy", o_busy, 0);
        chk("rst_we", o_ibuf_we, 0);
        chk("rst_start", o_start, 0);
        chk("rst_addr", o_ibuf_addr, 0);
        chk("rst_data", o_ibuf_wr_data, 0);
        tick();

        // Frame 1: a vector every 6 cycles
        for (int px = 0; px < NPX; px++) begin
            send_px(px);
            i_valid = 1'b0;
            repeat (5) tick();
        end
        wait_start();
        chk("frame1_writes", n_writes, OSZ);

        // fc busy from 3 cycles after start for 50 cycles; pool held off
        w0 = n_writes;
        for (int k = 1; k <= 53; k++) begin
            tick();
            if (k == 1)  drive_px(0);
            if (k == 3)  i_fc_busy = 1'b1;
            if (k == 53) i_fc_busy = 1'b0;
            @(negedge clk);
            if (k < 53) chk("busy_hold", o_busy, 1);
            else        chk("busy_release", o_busy, 0);
            if (k == 52) chk("hold_no_write", n_writes, w0);
        end
        tick();

        // Frame 2: valid every cycle, continuous writes
        first_wr  = -1;
        busy_seen = 1'b0;
        for (int px = 1; px < NPX; px++) send_px(px);
        i_valid   = 1'b0;
        i_fc_busy = 1'b1;
        wait_start();
        chk("frame2_writes", n_writes, 2 * OSZ);
        // 720 consecutive write cycles span 719 cycles first to last
        chk("frame2_span", last_wr - first_wr, OSZ - 1);
        chk("frame2_backpressure", busy_seen, 1);
        chk("frame2_drained", sb.size(), 0);

        // fc busy already high in START: no stall in WAIT_BUSY
        tick();
        @(negedge clk);
        chk("t6_wait_busy", o_busy, 1);
        tick();
        i_fc_busy = 1'b0;
        @(negedge clk);
        chk("t6_release", o_busy, 0);
        tick();
        @(negedge clk);
        chk("t6_fill", o_busy, 0);
        chk("t6_no_we", o_ibuf_we, 0);
        tick();

        // Reset in the middle of a frame
        for (int px = 0; px < 70; px++) send_px(px);
        i_valid = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        @(negedge clk);
        chk("midrst_busy", o_busy, 0);
        chk("midrst_we", o_ibuf_we, 0);
        chk("midrst_start", o_start, 0);
        chk("midrst_addr", o_ibuf_addr, 0);
        chk("midrst_data", o_ibuf_wr_data, 0);
        tick();
        s0 = n_starts;
        w0 = n_writes;
        for (int px = 0; px < NPX; px++) send_px((px * 3) % 7);
        i_valid = 1'b0;
        wait_start();
        repeat (4) tick();
        @(negedge clk);
        chk("frame3_one_start", n_starts - s0, 1);
        chk("frame3_writes", n_writes - w0, OSZ);
        chk("frame3_drained", sb.size(), 0);
        tick();
        i_fc_busy = 1'b1;
        tick();
        i_fc_busy = 1'b0;
        tick();

        // Small instance: 1 channel, 2x2 pixels
        for (int k = 0; k < 6; k++) begin
            tick();
            if (k < 4) begin
                s_valid   = 1'b1;
                s_data[0] = DW'(k);
            end else begin
                s_valid = 1'b0;
            end
            @(negedge clk);
            if (k < 4) chk("small_busy", s_busy, 0);
            if (k >= 1 && k <= 4) begin
                chk("small_we", s_we, 1);
                chk("small_addr", s_addr, k - 1);
                chk("small_data", s_wr_data, k - 1);
            end
            if (k == 4) chk("small_busy_done", s_busy, 1);
            if (k == 5) begin
                chk("small_start", s_start, 1);
                chk("small_we_off", s_we, 0);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
